dpram_burst_reader: RTL and testbench

Port-B read controller for the 8192x11 capture dual-port RAM. On a start pulse it reads a programmable number of consecutive words from a circular address (wrapping modulo DEPTH) and streams them out over a valid/ready interface with full backpressure support. It sits between the sample-capture RAM, whose port A is written by the acquisition path, and the display/FFT consumers. It hides the RAM's 1-cycle unregistered read latency behind a small output FIFO.

---
 rtl/dpram_burst_reader.sv | 212 +++++++++++++++++++++
 tb/tb_dpram_burst_reader.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_burst_reader.sv
// dpram_burst_reader: port-B burst read controller for the 8192x11 capture RAM.
// Reads a circular run of words and streams them over valid/ready. A small
// FIFO plus a two-stage read tag pipeline hides the RAM's one-cycle read
// latency. Reads only issue while FIFO occupancy plus reads in flight is
// below the FIFO depth, so backpressure can never overflow the FIFO.
//
// state   | meaning
// S_IDLE  | waiting for start; a zero-length start only pulses done
// S_READ  | issuing one read per cycle while FIFO credit is available
// S_DRAIN | every read issued; waiting for the last beat to handshake
module dpram_burst_reader #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 11,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = CNT_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    // Read tags: stage 1 = address presented to RAM, stage 2 = data on ram_rd_data.
    logic                  tag1_q, tag1_d;
    logic                  tag1_last_q, tag1_last_d;
    logic                  tag2_q, tag2_d;
    logic                  tag2_last_q, tag2_last_d;

    // FIFO entries hold {last, data}.
    logic [DATA_WIDTH:0]   fifo_mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH:0]   fifo_mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic                  flush;
    logic                  push;
    logic                  pop;
    logic                  credit_ok;
    logic [SUM_W-1:0]      pending;
    logic [DATA_WIDTH:0]   head;

    assign head      = fifo_mem_q[rd_ptr_q];
    assign m_valid   = (count_q != '0);
    assign m_data    = head[DATA_WIDTH-1:0];
    assign m_last    = m_valid & head[DATA_WIDTH];
    assign ram_addr  = ram_addr_q;
    assign busy      = busy_q;
    assign done      = done_q;

    assign push      = tag2_q;
    assign pop       = m_valid & m_ready;
    assign pending   = SUM_W'(count_q) + SUM_W'(tag1_q) + SUM_W'(tag2_q);
    assign credit_ok = (pending < SUM_W'(FIFO_DEPTH));

    // Burst sequencing: accept start, issue reads under credit, finish or abort.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        ram_addr_d  = ram_addr_q;
        remaining_d = remaining_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        tag1_d      = 1'b0;
        tag1_last_d = 1'b0;
        flush       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        // The first read issues on the accepting edge itself.
                        ram_addr_d  = start_addr;
                        addr_d      = start_addr + ADDR_WIDTH'(1);
                        remaining_d = length - LEN_WIDTH'(1);
                        tag1_d      = 1'b1;
                        tag1_last_d = (length == LEN_WIDTH'(1));
                        busy_d      = 1'b1;
                        state_d     = (length == LEN_WIDTH'(1)) ? S_DRAIN : S_READ;
                    end
                end
            end
            S_READ: begin
                if (abort) begin
                    flush   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (credit_ok) begin
                    ram_addr_d  = addr_q;
                    addr_d      = addr_q + ADDR_WIDTH'(1);
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                    tag1_d      = 1'b1;
                    tag1_last_d = (remaining_q == LEN_WIDTH'(1));
                    if (remaining_q == LEN_WIDTH'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    flush   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (pop && head[DATA_WIDTH]) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Tag pipeline advance and FIFO push/pop bookkeeping.
    always_comb begin
        tag2_d      = tag1_q & ~flush;
        tag2_last_d = tag1_last_q & ~flush;
        fifo_mem_d  = fifo_mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                fifo_mem_d[wr_ptr_q] = {tag2_last_q, ram_rd_data};
                wr_ptr_d             = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State register; FIFO storage is reset so m_data reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            ram_addr_q  <= '0;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            tag1_q      <= 1'b0;
            tag1_last_q <= 1'b0;
            tag2_q      <= 1'b0;
            tag2_last_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            ram_addr_q  <= ram_addr_d;
            remaining_q <= remaining_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            tag1_q      <= tag1_d;
            tag1_last_q <= tag1_last_d;
            tag2_q      <= tag2_d;
            tag2_last_q <= tag2_last_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            fifo_mem_q  <= fifo_mem_d;
        end
    end

endmodule

// File: tb/tb_dpram_burst_reader.sv
// Bench for dpram_burst_reader: a RAM model drives ram_rd_data, and a
// queue-based reference predicts every beat, busy and done cycle by cycle.
module tb_dpram_burst_reader;

    localparam int AW    = 13;
    localparam int DW    = 11;
    localparam int LW    = 14;
    localparam int DEPTH = 8192;
    localparam int FD    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          m_ready = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [LW-1:0] length = '0;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_rd_data;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_last;
    logic          busy;
    logic          done;

    logic [DW-1:0] ram [DEPTH];

    dpram_burst_reader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .start_addr  (start_addr),
        .length      (length),
        .abort       (abort),
        .ram_addr    (ram_addr),
        .ram_rd_data (ram_rd_data),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_last      (m_last),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // RAM port B: data appears the cycle after the address is clocked.
    always @(posedge clk) ram_rd_data <= ram[ram_addr];

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    beat_t         exp_q[$];
    beat_t         obs_q[$];
    beat_t         b;
    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc = 0;
    bit            exp_busy = 0;
    bit            exp_done = 0;
    bit            nb, nd;
    logic [AW-1:0] burst_sa = '0;
    logic [AW-1:0] idx;
    int            pops = 0;
    int            start_cyc = -1;
    int            first_valid_cyc = -1;
    int            done_cyc = -1;
    int            first_ok_cyc = 0;
    int            rdy_mode = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference model and per-cycle comparison, sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            exp_busy = 0;
            exp_done = 0;
            pops     = 0;
        end else begin
            check("busy", busy, exp_busy);
            check("done", done, exp_done);
            if (done) done_cyc = cyc;
            if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (exp_q.size() == 0 || cyc < first_ok_cyc) check("m_valid_early", m_valid, 1'b0);
            if (exp_busy) begin
                idx = ram_addr - burst_sa;
                check("credit", (int'(idx) < pops + FD), 1);
            end
            nb = exp_busy;
            nd = 0;
            if (exp_busy && abort) begin
                exp_q.delete();
                nb = 0;
            end else begin
                if (m_valid && m_ready && exp_q.size() > 0) begin
                    b = exp_q.pop_front();
                    obs_q.push_back(beat_t'({m_last, m_data}));
                    check("m_data", m_data, b.data);
                    check("m_last", m_last, b.last);
                    pops++;
                    if (b.last) begin
                        nd = 1;
                        nb = 0;
                    end
                end
                if (start && !exp_busy) begin
                    start_cyc       = cyc;
                    first_valid_cyc = -1;
                    done_cyc        = -1;
                    obs_q.delete();
                    if (length == '0) begin
                        nd = 1;
                    end else begin
                        burst_sa     = start_addr;
                        pops         = 0;
                        first_ok_cyc = cyc + 3;
                        nb           = 1;
                        for (int i = 0; i < int'(length); i++) begin
                            b.data = ram[(int'(start_addr) + i) % DEPTH];
                            b.last = (i == int'(length) - 1);
                            exp_q.push_back(b);
                        end
                    end
                end
            end
            exp_busy = nb;
            exp_done = nd;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b0;
        endcase
    endtask

    task automatic do_start(input int sa, input int len);
        start_addr = AW'(sa);
        length     = LW'(len);
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (exp_busy && n < budget) begin
            tick();
            n++;
        end
        if (exp_busy) begin
            n_cmp++;
            n_bad++;
            $display("FAIL burst_timeout: still busy after %0d cycles, required idle", budget);
        end
        tick();
        tick();
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, "_ram_addr"}, ram_addr, 0);
        check({pfx, "_m_data"}, m_data, 0);
        check({pfx, "_m_valid"}, m_valid, 0);
        check({pfx, "_m_last"}, m_last, 0);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_done"}, done, 0);
    endtask

    task automatic fill_identity();
        for (int a = 0; a < DEPTH; a++) ram[a] = DW'(a);
    endtask

    task automatic fill_random();
        for (int a = 0; a < DEPTH; a++) ram[a] = DW'($urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        fill_identity();
        rst_n    = 1'b0;
        rdy_mode = 0;
        repeat (3) tick();
        check_reset("reset");
        rst_n = 1'b1;
        repeat (2) tick();

        // Basic burst, no backpressure.
        do_start(100, 8);
        wait_idle(100);
        check("basic_first_valid", first_valid_cyc - start_cyc, 3);
        check("basic_done", done_cyc - start_cyc, 11);
        check("basic_beats", obs_q.size(), 8);
        check("basic_d0", obs_q[0].data, 100);
        check("basic_d7", obs_q[7].data, 107);
        check("basic_last7", obs_q[7].last, 1);
        check("basic_last6", obs_q[6].last, 0);

        // Address wrap 8191 -> 0.
        do_start(8190, 4);
        wait_idle(100);
        check("wrap_beats", obs_q.size(), 4);
        check("wrap_d0", obs_q[0].data, 2046);
        check("wrap_d1", obs_q[1].data, 2047);
        check("wrap_d2", obs_q[2].data, 0);
        check("wrap_d3", obs_q[3].data, 1);
        check("wrap_last", obs_q[3].last, 1);

        // Zero length: done only.
        do_start(50, 0);
        repeat (4) tick();
        check("len0_done", done_cyc - start_cyc, 1);
        check("len0_no_valid", first_valid_cyc, -1);

        // Start while busy is ignored.
        do_start(300, 12);
        repeat (3) tick();
        do_start(900, 5);
        wait_idle(100);
        check("busy_start_beats", obs_q.size(), 12);
        check("busy_start_d0", obs_q[0].data, 300);
        check("busy_start_d11", obs_q[11].data, 311);
        check("busy_start_done", done_cyc - start_cyc, 15);

        // Abort with the consumer stalled.
        rdy_mode = 2;
        do_start(1000, 20);
        repeat (6) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_valid", m_valid, 0);
        check("abort_busy", busy, 0);
        repeat (4) tick();
        check("abort_no_done", done_cyc, -1);
        rdy_mode = 0;
        do_start(500, 5);
        wait_idle(100);
        check("after_abort_beats", obs_q.size(), 5);
        check("after_abort_d0", obs_q[0].data, 500);

        // Random backpressure, 16 words.
        rdy_mode = 1;
        do_start(2040, 16);
        wait_idle(500);
        check("bp_beats", obs_q.size(), 16);

        // Randomized bursts with stray starts and occasional aborts.
        fill_random();
        for (int k = 0; k < 25; k++) begin
            rdy_mode = int'($urandom_range(0, 1));
            do_start(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 40)));
            n = 0;
            while (exp_busy && n < 2000) begin
                if ($urandom_range(0, 59) == 0) abort = 1'b1;
                if ($urandom_range(0, 19) == 0) begin
                    start      = 1'b1;
                    start_addr = AW'($urandom);
                    length     = LW'($urandom_range(1, 10));
                end
                tick();
                abort = 1'b0;
                start = 1'b0;
                n++;
            end
            wait_idle(10);
        end

        // Full-depth burst touches every address once.
        rdy_mode = 0;
        do_start(4000, DEPTH);
        wait_idle(9000);
        check("full_beats", obs_q.size(), DEPTH);
        check("full_last", obs_q[DEPTH-1].last, 1);
        check("full_done", done_cyc - start_cyc, DEPTH + 3);

        // Asynchronous reset mid-burst.
        rdy_mode = 1;
        do_start(10, 30);
        repeat (8) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("midrst");
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("post_rst_busy", busy, 0);
        check("post_rst_valid", m_valid, 0);
        rdy_mode = 0;
        do_start(20, 6);
        wait_idle(100);
        check("post_rst_beats", obs_q.size(), 6);
        check("post_rst_d0", obs_q[0].data, ram[20]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
